// File: rtl/sbox_sub_engine.sv
// sbox_sub_engine: time-multiplexed AES SubBytes / InvSubBytes engine.
// An NBYTES-byte block is latched on accept, then LANES bytes per cycle are
// pushed through forward or inverse S-box ROMs (lowest byte indices first).
// The finished block is offered on a valid/ready output until it is taken.
// Used for both the cipher state (NBYTES=16) and key-schedule SubWord (NBYTES=4).

module sbox_sub_engine #(
  parameter int NBYTES = 16,
  parameter int LANES  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_data,
  input  logic                  in_inv,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_data,
  output logic                  busy
);

  // Guarded divisor so a bad LANES value reaches the fatal check below
  // instead of tripping a divide-by-zero during elaboration.
  localparam int lanes_safe = (LANES >= 1) ? LANES : 1;
  localparam int chunks     = NBYTES / lanes_safe;
  localparam int cw         = (chunks > 1) ? $clog2(chunks) : 1;

  localparam logic [cw-1:0] cnt_zero = {cw{1'b0}};
  localparam logic [cw-1:0] cnt_one  = cw'(1'b1);
  localparam logic [cw-1:0] cnt_last = cw'(chunks - 1);

  generate
    if ((LANES < 1) || (LANES > NBYTES) || ((NBYTES % lanes_safe) != 0)) begin : g_param_check
      $fatal(1, "sbox_sub_engine: NBYTES must be a non-zero multiple of LANES");
    end
  endgenerate

  // Forward AES S-box, indexed by input byte.
  localparam logic [7:0] sbox_fwd [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Inverse AES S-box, indexed by input byte.
  localparam logic [7:0] sbox_inv [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_busy = 2'd1,
    st_done = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [cw-1:0]        cnt_r;
  logic [cw-1:0]        cnt_nxt_s;
  logic [8*NBYTES-1:0]  src_r;
  logic                 mode_r;
  logic [8*NBYTES-1:0]  result_r;
  logic [8*NBYTES-1:0]  result_nxt_s;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic                 busy_r;
  logic                 accept_s;
  logic [7:0]           src_byte_s [LANES];
  logic [7:0]           sub_byte_s [LANES];

  assign accept_s  = (state_r == st_idle) && in_valid;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_data  = result_r;

  // Select the LANES source bytes belonging to the chunk addressed by cnt_r.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      src_byte_s[l] = 8'h00;
      for (int c = 0; c < chunks; c++) begin
        src_byte_s[l] = (cnt_r == cw'(c)) ? src_r[8*(c*LANES+l) +: 8] : src_byte_s[l];
      end
    end
  end

  // One forward and one inverse ROM per lane, picked by the latched block mode.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      sub_byte_s[l] = mode_r ? sbox_inv[src_byte_s[l]] : sbox_fwd[src_byte_s[l]];
    end
  end

  // Merge the substituted lane bytes into their chunk of the result block.
  always_comb begin
    result_nxt_s = result_r;
    for (int c = 0; c < chunks; c++) begin
      for (int l = 0; l < LANES; l++) begin
        if (cnt_r == cw'(c)) begin
          result_nxt_s[8*(c*LANES+l) +: 8] = sub_byte_s[l];
        end else begin
          result_nxt_s[8*(c*LANES+l) +: 8] = result_r[8*(c*LANES+l) +: 8];
        end
      end
    end
  end

  // Next-state and chunk-counter logic for the IDLE -> BUSY -> DONE cycle.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      st_idle: begin
        if (in_valid) begin
          state_nxt_s = st_busy;
          cnt_nxt_s   = cnt_zero;
        end else begin
          state_nxt_s = st_idle;
          cnt_nxt_s   = cnt_r;
        end
      end
      st_busy: begin
        if (cnt_r == cnt_last) begin
          state_nxt_s = st_done;
          cnt_nxt_s   = cnt_zero;
        end else begin
          state_nxt_s = st_busy;
          cnt_nxt_s   = cnt_r + cnt_one;
        end
      end
      st_done: begin
        if (out_ready) begin
          state_nxt_s = st_idle;
        end else begin
          state_nxt_s = st_done;
        end
      end
      default: begin
        state_nxt_s = st_idle;
        cnt_nxt_s   = cnt_zero;
      end
    endcase
  end

  // State register plus handshake outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= st_idle;
      cnt_r       <= cnt_zero;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      in_ready_r  <= (state_nxt_s == st_idle);
      out_valid_r <= (state_nxt_s == st_done);
      busy_r      <= (state_nxt_s != st_idle);
    end
  end

  // Block datapath: latch source and mode on accept, fill result while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_r    <= {(8*NBYTES){1'b0}};
      mode_r   <= 1'b0;
      result_r <= {(8*NBYTES){1'b0}};
    end else begin
      if (accept_s) begin
        src_r  <= in_data;
        mode_r <= in_inv;
      end
      if (state_r == st_busy) begin
        result_r <= result_nxt_s;
      end
    end
  end

endmodule

// File: tb/tb_sbox_sub_engine.sv
// Directed bench for sbox_sub_engine: default (16,4) instance for the
// functional, backpressure and reset scenarios, plus four more instances
// covering other NBYTES/LANES splits against an algebraic S-box model.

module tb_sbox_sub_engine;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  // Default configuration instance
  logic         m_in_valid, m_in_ready, m_in_inv, m_out_valid, m_out_ready, m_busy;
  logic [127:0] m_in_data, m_out_data;

  sbox_sub_engine #(.NBYTES(16), .LANES(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data), .in_inv(m_in_inv),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_data(m_out_data), .busy(m_busy)
  );

  // Sweep instances: (4,1) (4,4) (16,16) (16,2)
  logic         sw_in_valid [4];
  logic         sw_in_ready [4];
  logic         sw_in_inv [4];
  logic         sw_out_valid [4];
  logic         sw_out_ready [4];
  logic         sw_busy [4];
  logic [127:0] sw_in_data [4];
  logic [127:0] sw_out [4];
  logic [31:0]  od0, od1;
  logic [127:0] od2, od3;

  assign sw_out[0] = {96'h0, od0};
  assign sw_out[1] = {96'h0, od1};
  assign sw_out[2] = od2;
  assign sw_out[3] = od3;

  sbox_sub_engine #(.NBYTES(4), .LANES(1)) u_sw0 (
    .clk(clk), .reset(reset),
    .in_valid(sw_in_valid[0]), .in_ready(sw_in_ready[0]), .in_data(sw_in_data[0][31:0]), .in_inv(sw_in_inv[0]),
    .out_valid(sw_out_valid[0]), .out_ready(sw_out_ready[0]), .out_data(od0), .busy(sw_busy[0])
  );
  sbox_sub_engine #(.NBYTES(4), .LANES(4)) u_sw1 (
    .clk(clk), .reset(reset),
    .in_valid(sw_in_valid[1]), .in_ready(sw_in_ready[1]), .in_data(sw_in_data[1][31:0]), .in_inv(sw_in_inv[1]),
    .out_valid(sw_out_valid[1]), .out_ready(sw_out_ready[1]), .out_data(od1), .busy(sw_busy[1])
  );
  sbox_sub_engine #(.NBYTES(16), .LANES(16)) u_sw2 (
    .clk(clk), .reset(reset),
    .in_valid(sw_in_valid[2]), .in_ready(sw_in_ready[2]), .in_data(sw_in_data[2]), .in_inv(sw_in_inv[2]),
    .out_valid(sw_out_valid[2]), .out_ready(sw_out_ready[2]), .out_data(od2), .busy(sw_busy[2])
  );
  sbox_sub_engine #(.NBYTES(16), .LANES(2)) u_sw3 (
    .clk(clk), .reset(reset),
    .in_valid(sw_in_valid[3]), .in_ready(sw_in_ready[3]), .in_data(sw_in_data[3]), .in_inv(sw_in_inv[3]),
    .out_valid(sw_out_valid[3]), .out_ready(sw_out_ready[3]), .out_data(od3), .busy(sw_busy[3])
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] ref_fwd [256];
  logic [7:0] ref_inv [256];

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box built from the field inverse and the affine map
  task automatic build_ref();
    logic [7:0] b;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      end
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      ref_fwd[x] = s;
      ref_inv[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_block(input logic [127:0] d, input logic inv, input int nb);
    logic [127:0] r;
    r = 128'h0;
    for (int i = 0; i < nb; i++) begin
      r[8*i +: 8] = inv ? ref_inv[d[8*i +: 8]] : ref_fwd[d[8*i +: 8]];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic main_send(input logic [127:0] d, input logic inv);
    m_in_data  = d;
    m_in_inv   = inv;
    m_in_valid = 1'b1;
    step();
    m_in_valid = 1'b0;
  endtask

  // Counts edges after accept until out_valid; optionally scrambles inputs meanwhile
  task automatic main_wait(input bit scramble, output int lat, output bit busy_bad);
    lat = 0;
    busy_bad = 1'b0;
    while (m_out_valid !== 1'b1 && lat < 64) begin
      if (m_busy !== 1'b1) busy_bad = 1'b1;
      if (scramble) begin
        m_in_inv  = ~m_in_inv;
        m_in_data = {$urandom, $urandom, $urandom, $urandom};
      end
      step();
      lat++;
    end
  endtask

  task automatic main_take();
    m_out_ready = 1'b1;
    step();
    m_out_ready = 1'b0;
  endtask

  task automatic run_sweep(input int k, input int nb, input int lanes, input int nblk);
    logic [127:0] d;
    logic         inv;
    int           lat;
    for (int b = 0; b < nblk; b++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      if (nb == 4) d[127:32] = 96'h0;
      inv = 1'($urandom_range(1, 0));
      check($sformatf("sw%0d_in_ready", k), 128'(sw_in_ready[k]), 128'd1);
      sw_in_data[k]  = d;
      sw_in_inv[k]   = inv;
      sw_in_valid[k] = 1'b1;
      step();
      sw_in_valid[k] = 1'b0;
      lat = 0;
      while (sw_out_valid[k] !== 1'b1 && lat < 64) begin
        step();
        lat++;
      end
      check($sformatf("sw%0d_latency", k), 128'(lat), 128'(nb / lanes));
      check($sformatf("sw%0d_data", k), sw_out[k], ref_block(d, inv, nb));
      sw_out_ready[k] = 1'b1;
      step();
      sw_out_ready[k] = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d2;
    logic [127:0] r;
    logic [127:0] held;
    int           lat;
    bit           busy_bad;
    bit           bp_bad;

    reset = 1'b1;
    m_in_valid = 1'b0; m_in_inv = 1'b0; m_in_data = 128'h0; m_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sw_in_valid[k] = 1'b0; sw_in_inv[k] = 1'b0; sw_in_data[k] = 128'h0; sw_out_ready[k] = 1'b0;
    end
    build_ref();
    step(); step();
    reset = 1'b0;

    // Reset state
    check("rst_in_ready", 128'(m_in_ready), 128'd1);
    check("rst_out_valid", 128'(m_out_valid), 128'd0);
    check("rst_out_data", m_out_data, 128'h0);
    check("rst_busy", 128'(m_busy), 128'd0);

    // 1: forward all-zero block
    main_send(128'h0, 1'b0);
    check("t1_in_ready_low", 128'(m_in_ready), 128'd0);
    main_wait(1'b0, lat, busy_bad);
    check("t1_latency", 128'(lat), 128'd4);
    check("t1_busy", 128'(busy_bad), 128'd0);
    check("t1_data", m_out_data, {16{8'h63}});
    main_take();
    check("t1_in_ready_after", 128'(m_in_ready), 128'd1);
    check("t1_busy_after", 128'(m_busy), 128'd0);
    check("t1_out_valid_after", 128'(m_out_valid), 128'd0);

    // 2: known bytes
    d2 = {8'hff, {13{8'h00}}, 8'h01, 8'h53};
    main_send(d2, 1'b0);
    main_wait(1'b0, lat, busy_bad);
    check("t2_latency", 128'(lat), 128'd4);
    check("t2_data", m_out_data, {8'h16, {13{8'h63}}, 8'h7c, 8'hed});
    r = m_out_data;
    main_take();

    // 3: inverse round trip, inputs scrambled while busy
    main_send(r, 1'b1);
    main_wait(1'b1, lat, busy_bad);
    check("t3_latency", 128'(lat), 128'd4);
    check("t3_data", m_out_data, d2);
    main_take();

    // 4: backpressure in DONE with in_valid held high
    main_send(128'h00112233445566778899aabbccddeeff, 1'b0);
    main_wait(1'b0, lat, busy_bad);
    check("t4_data", m_out_data, ref_block(128'h00112233445566778899aabbccddeeff, 1'b0, 16));
    held = m_out_data;
    bp_bad = 1'b0;
    m_in_valid = 1'b1;
    m_in_data  = {4{32'hdeadbeef}};
    for (int i = 0; i < 10; i++) begin
      step();
      if (m_out_valid !== 1'b1 || m_in_ready !== 1'b0 || m_out_data !== held) bp_bad = 1'b1;
    end
    check("t4_hold", 128'(bp_bad), 128'd0);
    m_in_valid = 1'b0;
    main_take();
    check("t4_in_ready_after", 128'(m_in_ready), 128'd1);
    check("t4_out_valid_after", 128'(m_out_valid), 128'd0);

    // 5: reset during the second BUSY cycle
    main_send(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 1'b0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_in_ready", 128'(m_in_ready), 128'd1);
    check("t5_out_valid", 128'(m_out_valid), 128'd0);
    check("t5_out_data", m_out_data, 128'h0);
    check("t5_busy", 128'(m_busy), 128'd0);
    bp_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (m_out_valid !== 1'b0) bp_bad = 1'b1;
    end
    check("t5_no_stale_output", 128'(bp_bad), 128'd0);
    main_send(128'h0, 1'b0);
    main_wait(1'b0, lat, busy_bad);
    check("t5_latency", 128'(lat), 128'd4);
    check("t5_data", m_out_data, {16{8'h63}});
    main_take();

    // 6: parameter sweep
    run_sweep(0, 4, 1, 6);
    run_sweep(1, 4, 4, 6);
    run_sweep(2, 16, 16, 6);
    run_sweep(3, 16, 2, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
